// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader and its neighbours.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 128;
    localparam int unsigned IMEM_AW    = 7;
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_arb_if.sv
// Bus bundle between the loader/arbiter, the CPU fetch stage, the UART receiver and the memory.
interface imem_loader_arb_if #(
    parameter int unsigned AW = imem_pkg::IMEM_AW
);
    logic [30:0]   cpu_addr;
    logic [31:0]   cpu_instr;
    logic          cpu_hold;
    logic          cpu_restart;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          load_busy;
    logic          load_err;

    // Arbiter side
    modport master (
        input  cpu_addr, rx_data, rx_valid, mem_rdata,
        output cpu_instr, cpu_hold, cpu_restart, rx_ready,
               mem_addr, mem_wdata, mem_we, load_busy, load_err
    );

    // CPU / UART / memory side
    modport slave (
        output cpu_addr, rx_data, rx_valid, mem_rdata,
        input  cpu_instr, cpu_hold, cpu_restart, rx_ready,
               mem_addr, mem_wdata, mem_we, load_busy, load_err
    );
endinterface

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running XOR of all bytes.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word_c,
    output logic        word_done_c,
    output logic [7:0]  xor_acc
);

    logic [23:0] shreg_q;
    logic [1:0]  cnt_q;

    // The completed word is presented in the same cycle as its 4th byte.
    assign word_c      = {data_byte, shreg_q};
    assign word_done_c = strobe && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            xor_acc <= '0;
        end else if (clear) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            xor_acc <= '0;
        end else if (strobe) begin
            shreg_q <= {data_byte, shreg_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
            xor_acc <= xor_acc ^ data_byte;
        end
    end

endmodule

// File: rtl/imem_loader_arb.sv
// Instruction-memory owner: serves CPU fetches and loads framed program images from the UART.
module imem_loader_arb
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned AW    = IMEM_AW,
    parameter logic [7:0]  SYNC  = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_arb_if.master bus
);

    state_t        state_q, state_n;
    logic          xfer;
    logic [7:0]    n_len_q;
    logic [AW-1:0] word_idx_q;
    logic [31:0]   wr_data_q;
    logic          mem_we_q;
    logic [31:0]   asm_word_c;
    logic          asm_done_c;
    logic [7:0]    xor_acc;
    logic          last_word_c;
    logic          out_of_range_c;
    logic          hold_c, ready_c, busy_c, err_c, restart_c;
    logic          unused_addr_lsbs;

    assign xfer           = bus.rx_valid && ready_c;
    assign last_word_c    = (32'(word_idx_q) + 32'd1) == 32'(n_len_q);
    assign out_of_range_c = bus.cpu_addr[30:2] >= 29'(DEPTH);
    assign unused_addr_lsbs = ^bus.cpu_addr[1:0];

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (reset),
        .data_byte   (bus.rx_data),
        .strobe      (xfer && (state_q == DATA)),
        .clear       (xfer && (state_q == LEN)),
        .word_c      (asm_word_c),
        .word_done_c (asm_done_c),
        .xor_acc     (xor_acc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (xfer && (bus.rx_data == SYNC)) state_n = LEN;
            LEN: begin
                if (xfer) begin
                    if ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > DEPTH)) state_n = ERR;
                    else                                                     state_n = DATA;
                end
            end
            DATA: if (asm_done_c && last_word_c) state_n = CSUM;
            CSUM: begin
                if (xfer) state_n = (bus.rx_data == xor_acc) ? DONE : ERR;
            end
            DONE: state_n = IDLE;
            ERR:  if (xfer && (bus.rx_data == SYNC)) state_n = LEN;
            default: state_n = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        hold_c    = 1'b1;
        ready_c   = 1'b1;
        busy_c    = 1'b0;
        err_c     = 1'b0;
        restart_c = 1'b0;
        case (state_q)
            IDLE:            hold_c = 1'b0;
            LEN, DATA, CSUM: busy_c = 1'b1;
            DONE: begin
                restart_c = 1'b1;
                ready_c   = 1'b0;
            end
            ERR:             err_c = 1'b1;
            default:         hold_c = 1'b0;
        endcase
    end

    // Write path: a captured word is written the cycle after its 4th byte, then the index advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_q   <= 1'b0;
            wr_data_q  <= '0;
            n_len_q    <= '0;
            word_idx_q <= '0;
        end else begin
            mem_we_q <= asm_done_c;
            if (asm_done_c) wr_data_q <= asm_word_c;
            if (xfer && (state_q == LEN)) begin
                n_len_q    <= bus.rx_data;
                word_idx_q <= '0;
            end else if (mem_we_q) begin
                word_idx_q <= word_idx_q + AW'(1);
            end
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = wr_data_q;
    assign bus.mem_addr    = mem_we_q ? word_idx_q : bus.cpu_addr[AW+1:2];
    assign bus.cpu_instr   = (hold_c || out_of_range_c) ? NOP_WORD : bus.mem_rdata;
    assign bus.cpu_hold    = hold_c;
    assign bus.cpu_restart = restart_c;
    assign bus.rx_ready    = ready_c;
    assign bus.load_busy   = busy_c;
    assign bus.load_err    = err_c;

endmodule

// File: tb/tb_imem_loader_arb.sv
// Scoreboarded bench for imem_loader_arb: frame loads, errors, fetch gating, gaps and reset mid-load.
module tb_imem_loader_arb;
    import imem_pkg::*;

    localparam int unsigned AW    = IMEM_AW;
    localparam int unsigned DEPTH = IMEM_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_loader_arb_if #(.AW(AW)) bus();

    imem_loader_arb #(.DEPTH(DEPTH), .AW(AW), .SYNC(SYNC_BYTE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int vectors = 0;
    int miscompares = 0;
    int restart_cnt = 0;
    int we_cnt = 0;
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_data [$];
    logic [AW-1:0] mon_a;
    logic [31:0]   mon_d;

    // Write monitor: every mem_we must match the next expected write
    initial forever begin
        @(negedge clk);
        if (bus.cpu_restart === 1'b1) restart_cnt++;
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            vectors++;
            if (exp_addr.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_we got addr=%0d data=%h, none expected", bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                if (bus.mem_addr !== mon_a || bus.mem_wdata !== mon_d) begin
                    miscompares++;
                    $display("FAIL mem_write got addr=%0d data=%h exp addr=%0d data=%h",
                             bus.mem_addr, bus.mem_wdata, mon_a, mon_d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        while (bus.rx_ready !== 1'b1) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 20) begin
                vectors++; miscompares++;
                $display("FAIL rx_ready_timeout got rx_ready=%b exp 1", bus.rx_ready);
                return;
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
    endfunction

    // Drives a full frame and queues its expected writes; records hold/fetch anomalies seen after each byte.
    task automatic send_frame(input logic [31:0] w[$], input int max_gap, input logic [7:0] flip,
                              output bit hold_low, output bit fetch_nz);
        logic [7:0] csum = 8'h00;
        logic [7:0] b;
        hold_low = 1'b0;
        fetch_nz = 1'b0;
        for (int i = 0; i < w.size(); i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(w[i]);
        end
        send_byte(SYNC_BYTE, pick_gap(max_gap));
        if (bus.cpu_hold !== 1'b1) hold_low = 1'b1;
        send_byte(8'(w.size()), pick_gap(max_gap));
        if (bus.cpu_hold !== 1'b1) hold_low = 1'b1;
        for (int i = 0; i < w.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = w[i][8*k +: 8];
                csum = csum ^ b;
                send_byte(b, pick_gap(max_gap));
                if (bus.cpu_hold !== 1'b1) hold_low = 1'b1;
                if (bus.cpu_instr !== 32'h0) fetch_nz = 1'b1;
            end
        end
        send_byte(csum ^ flip, 0);
        if (bus.cpu_hold !== 1'b1) hold_low = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_mem();
        mem_clear = 1'b1;
        @(posedge clk); #1;
        mem_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.cpu_addr = 31'h0;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.cpu_hold !== 1'b0)    begin miscompares++; $display("FAIL reset_hold got %b exp 0", bus.cpu_hold); end
        vectors++; if (bus.load_busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.load_busy); end
        vectors++; if (bus.load_err !== 1'b0)    begin miscompares++; $display("FAIL reset_err got %b exp 0", bus.load_err); end
        vectors++; if (bus.rx_ready !== 1'b1)    begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.rx_ready); end
        vectors++; if (bus.cpu_restart !== 1'b0) begin miscompares++; $display("FAIL reset_restart got %b exp 0", bus.cpu_restart); end
        vectors++; if (bus.mem_we !== 1'b0)      begin miscompares++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
        reset = 1'b1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        logic [31:0] w[$] = '{32'h3c094000, 32'h3525001c};
        bit hl, fz;
        int r0 = restart_cnt;
        bus.cpu_addr = 31'h4;
        send_frame(w, 0, 8'h00, hl, fz);
        vectors++; if (hl !== 1'b0) begin miscompares++; $display("FAIL load_hold got low-seen=%b exp 0", hl); end
        vectors++; if (fz !== 1'b0) begin miscompares++; $display("FAIL load_fetch got nonzero-seen=%b exp 0", fz); end
        vectors++; if (bus.cpu_restart !== 1'b1) begin miscompares++; $display("FAIL done_restart got %b exp 1", bus.cpu_restart); end
        vectors++; if (bus.rx_ready !== 1'b0)    begin miscompares++; $display("FAIL done_ready got %b exp 0", bus.rx_ready); end
        vectors++; if (bus.cpu_hold !== 1'b1)    begin miscompares++; $display("FAIL done_hold got %b exp 1", bus.cpu_hold); end
        @(posedge clk); #1;
        vectors++; if (bus.cpu_hold !== 1'b0)    begin miscompares++; $display("FAIL idle_hold got %b exp 0", bus.cpu_hold); end
        vectors++; if (bus.cpu_restart !== 1'b0) begin miscompares++; $display("FAIL idle_restart got %b exp 0", bus.cpu_restart); end
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (restart_cnt - r0 !== 1) begin miscompares++; $display("FAIL restart_count got %0d exp 1", restart_cnt - r0); end
        vectors++; if (exp_addr.size() !== 0)  begin miscompares++; $display("FAIL writes_pending got %0d exp 0", exp_addr.size()); end
        vectors++; if (mem[0] !== w[0]) begin miscompares++; $display("FAIL mem0 got %h exp %h", mem[0], w[0]); end
        vectors++; if (mem[1] !== w[1]) begin miscompares++; $display("FAIL mem1 got %h exp %h", mem[1], w[1]); end
    endtask

    task automatic test_fetch();
        bus.cpu_addr = 31'h4; #1;
        vectors++; if (bus.cpu_instr !== 32'h3525001c) begin miscompares++; $display("FAIL fetch_w1 got %h exp 3525001c", bus.cpu_instr); end
        bus.cpu_addr = 31'h0; #1;
        vectors++; if (bus.cpu_instr !== 32'h3c094000) begin miscompares++; $display("FAIL fetch_w0 got %h exp 3c094000", bus.cpu_instr); end
        bus.cpu_addr = 31'h7; #1;
        vectors++; if (bus.cpu_instr !== 32'h3525001c) begin miscompares++; $display("FAIL fetch_off got %h exp 3525001c", bus.cpu_instr); end
        bus.cpu_addr = 31'h200; #1;
        vectors++; if (bus.cpu_instr !== 32'h0) begin miscompares++; $display("FAIL fetch_oor got %h exp 0", bus.cpu_instr); end
        bus.cpu_addr = 31'h4;
        @(posedge clk); #1;
    endtask

    task automatic test_bad_csum();
        logic [31:0] wb[$] = '{32'h11223344, 32'h55667788};
        logic [31:0] w[$]  = '{32'h3c094000, 32'h3525001c};
        bit hl, fz;
        int r0 = restart_cnt;
        bus.cpu_addr = 31'h4;
        send_frame(wb, 0, 8'h01, hl, fz);
        vectors++; if (fz !== 1'b0) begin miscompares++; $display("FAIL busy_fetch got nonzero-seen=%b exp 0", fz); end
        vectors++; if (bus.load_err !== 1'b1)    begin miscompares++; $display("FAIL csum_err got %b exp 1", bus.load_err); end
        vectors++; if (bus.cpu_hold !== 1'b1)    begin miscompares++; $display("FAIL csum_hold got %b exp 1", bus.cpu_hold); end
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (restart_cnt - r0 !== 0) begin miscompares++; $display("FAIL csum_restart got %0d exp 0", restart_cnt - r0); end
        vectors++; if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", bus.load_err); end
        send_frame(w, 0, 8'h00, hl, fz);
        vectors++; if (bus.cpu_restart !== 1'b1) begin miscompares++; $display("FAIL recover_restart got %b exp 1", bus.cpu_restart); end
        vectors++; if (bus.load_err !== 1'b0)    begin miscompares++; $display("FAIL recover_err got %b exp 0", bus.load_err); end
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (bus.cpu_hold !== 1'b0)  begin miscompares++; $display("FAIL recover_hold got %b exp 0", bus.cpu_hold); end
        vectors++; if (restart_cnt - r0 !== 1) begin miscompares++; $display("FAIL recover_count got %0d exp 1", restart_cnt - r0); end
        vectors++; if (mem[1] !== w[1]) begin miscompares++; $display("FAIL recover_mem1 got %h exp %h", mem[1], w[1]); end
    endtask

    task automatic test_len_err();
        int we0, r0;
        apply_reset();
        we0 = we_cnt;
        r0 = restart_cnt;
        send_byte(SYNC_BYTE, 0);
        send_byte(8'h00, 0);
        vectors++; if (bus.load_err !== 1'b1)  begin miscompares++; $display("FAIL len0_err got %b exp 1", bus.load_err); end
        vectors++; if (bus.load_busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy got %b exp 0", bus.load_busy); end
        send_byte(8'h3c, 0);
        vectors++; if (bus.load_err !== 1'b1)  begin miscompares++; $display("FAIL err_discard got %b exp 1", bus.load_err); end
        send_byte(SYNC_BYTE, 0);
        vectors++; if (bus.load_err !== 1'b0)  begin miscompares++; $display("FAIL err_resync got %b exp 0", bus.load_err); end
        vectors++; if (bus.load_busy !== 1'b1) begin miscompares++; $display("FAIL resync_busy got %b exp 1", bus.load_busy); end
        send_byte(8'd129, 0);
        vectors++; if (bus.load_err !== 1'b1)  begin miscompares++; $display("FAIL len129_err got %b exp 1", bus.load_err); end
        send_byte(SYNC_BYTE, 0);
        send_byte(8'd128, 0);
        vectors++; if (bus.load_err !== 1'b0 || bus.load_busy !== 1'b1)
            begin miscompares++; $display("FAIL len128 got err=%b busy=%b exp err=0 busy=1", bus.load_err, bus.load_busy); end
        repeat (4) begin @(posedge clk); #1; end
        vectors++; if (we_cnt - we0 !== 0) begin miscompares++; $display("FAIL len_we got %0d writes exp 0", we_cnt - we0); end
        vectors++; if (restart_cnt - r0 !== 0) begin miscompares++; $display("FAIL len_restart got %0d exp 0", restart_cnt - r0); end
    endtask

    task automatic test_gaps();
        logic [31:0] wg[$] = '{32'hA51234A5, 32'h000000A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        logic [31:0] snap [4];
        bit hl, fz;
        int r0;
        apply_reset();
        r0 = restart_cnt;
        send_frame(wg, 0, 8'h00, hl, fz);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) snap[i] = mem[i];
        clear_mem();
        send_frame(wg, 5, 8'h00, hl, fz);
        vectors++; if (hl !== 1'b0) begin miscompares++; $display("FAIL gap_hold got low-seen=%b exp 0", hl); end
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[i] !== snap[i] || mem[i] !== wg[i]) begin
                miscompares++;
                $display("FAIL gap_mem%0d got %h exp %h (gap-free %h)", i, mem[i], wg[i], snap[i]);
            end
        end
        vectors++; if (restart_cnt - r0 !== 2) begin miscompares++; $display("FAIL gap_restart got %0d exp 2", restart_cnt - r0); end
        vectors++; if (exp_addr.size() !== 0)  begin miscompares++; $display("FAIL gap_pending got %0d exp 0", exp_addr.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0 = 32'hCAFE0123;
        logic [31:0] w1 = 32'h89ABCDEF;
        int r0;
        apply_reset();
        r0 = restart_cnt;
        exp_addr.push_back(AW'(0));
        exp_data.push_back(w0);
        send_byte(SYNC_BYTE, 0);
        send_byte(8'd2, 0);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
        send_byte(w1[7:0], 0);
        reset = 1'b0;
        #1;
        vectors++; if (bus.cpu_hold !== 1'b0)    begin miscompares++; $display("FAIL mid_hold got %b exp 0", bus.cpu_hold); end
        vectors++; if (bus.mem_we !== 1'b0)      begin miscompares++; $display("FAIL mid_we got %b exp 0", bus.mem_we); end
        vectors++; if (bus.load_busy !== 1'b0)   begin miscompares++; $display("FAIL mid_busy got %b exp 0", bus.load_busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        vectors++; if (bus.cpu_hold !== 1'b0)  begin miscompares++; $display("FAIL mid_idle_hold got %b exp 0", bus.cpu_hold); end
        vectors++; if (restart_cnt - r0 !== 0) begin miscompares++; $display("FAIL mid_restart got %0d exp 0", restart_cnt - r0); end
        vectors++; if (exp_addr.size() !== 0)  begin miscompares++; $display("FAIL mid_pending got %0d exp 0", exp_addr.size()); end
        vectors++; if (mem[0] !== w0)          begin miscompares++; $display("FAIL mid_mem0 got %h exp %h", mem[0], w0); end
        vectors++; if (mem[1] !== 32'h0)       begin miscompares++; $display("FAIL mid_mem1 got %h exp 0", mem[1]); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_fetch();
        test_bad_csum();
        test_len_err();
        test_gaps();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader_arb.md
Name: imem_loader_arb

Overview:
- Owns the single-port instruction memory that feeds the single-cycle CPU's fetch stage.
- Serves CPU fetches normally. Also accepts a framed program image as a byte stream from the UART receiver and writes it into memory word by word.
- Holds the CPU while a load is in progress, then pulses a restart so execution begins again at PC 0 with the new image.

Parameters:
- DEPTH, 128, number of 32-bit instruction words.
- AW, 7, memory word-address width; equals log2(DEPTH).
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_addr  in  31  CPU fetch byte address; the word index is cpu_addr[30:2]
- cpu_instr  out  32  instruction returned to the CPU
- cpu_hold  out  1  stalls the CPU PC and register writes while high
- cpu_restart  out  1  one-cycle pulse; the CPU resets its PC to 0
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read data; combinational read of mem_addr
- load_busy  out  1  high in states LEN, DATA and CSUM
- load_err  out  1  high in state ERR

Behaviour:
- Frame format: SYNC, then N (word count), then 4*N data bytes with each word sent little-endian (byte0 = bits[7:0]), then CSUM. CSUM is the XOR of all data bytes only.
- State machine: IDLE, LEN, DATA, CSUM, DONE, ERR. State is registered.
- Reset (asynchronous, active-low): state=IDLE, word index=0, byte count=0, XOR accumulator=0, mem_we=0, cpu_restart=0.
  - Outputs during reset: cpu_hold=0, load_busy=0, load_err=0, rx_ready=1.
- rx_ready is 1 in every state except DONE.
- IDLE:
  - cpu_hold=0.
  - Accepted byte == SYNC -> LEN. Any other byte is discarded.
- LEN:
  - cpu_hold=1.
  - Accepted N == 0 or N > DEPTH -> ERR.
  - Otherwise latch N, clear word index, byte count and XOR -> DATA.
- DATA:
  - cpu_hold=1. Every accepted byte is XORed into the accumulator and shifted into the assembly register.
  - A SYNC value received here is treated as data.
  - When the 4th byte of a word is accepted, the full word is captured in a write register.
  - In the next cycle: mem_we=1, mem_addr=word index, mem_wdata=captured word.
  - rx_ready stays 1 during that write cycle, so back-to-back bytes are legal.
  - Word index increments after each write. When the last word's 4th byte is accepted -> CSUM; its write still occurs in the following cycle.
- CSUM:
  - Accepted byte == accumulator -> DONE.
  - Otherwise -> ERR.
- DONE:
  - Exactly one cycle: cpu_restart=1, cpu_hold=1, rx_ready=0 -> IDLE.
- ERR:
  - cpu_hold=1, load_err=1. Non-SYNC bytes are discarded.
  - SYNC -> LEN; load_err drops in the same transition.
- Fetch path:
  - When mem_we=0, mem_addr = cpu_addr[AW+1:2].
  - cpu_instr = 0 (NOP) if cpu_hold=1 or cpu_addr[30:2] >= DEPTH; otherwise mem_rdata.
  - mem_we is only asserted while cpu_hold=1, so fetch and write never conflict.
- Gaps in rx_valid are allowed anywhere; the FSM waits with no timeout.
- Reset mid-load: immediate return to IDLE and cpu_hold released. Words already written stay in memory; no restart pulse is generated.
- The memory array itself is external to this block; the block does not initialise memory.

Decomposition:
- Shared package (imem_pkg):
  - state enum localparams: IDLE, LEN, DATA, CSUM, DONE, ERR
  - SYNC byte value
  - NOP word 32'h0
  - DEPTH/AW defaults, reused by the CPU top and the memory
- Sub-module word_assembler:
  - inputs: byte, strobe, clear
  - outputs: 32-bit word, word_done pulse, running XOR

Test Plan:
- Full load, N=2, words 32'h3c094000 and 32'h3525001c:
  - stimulus: A5, 02, 00 40 09 3c, 1c 00 25 35, CSUM=XOR of those 8 data bytes
  - required: mem_we at addresses 0 then 1 with the correct data; cpu_restart pulses exactly once; cpu_hold is 1 from the LEN byte through the DONE cycle and 0 afterwards.
- Bad checksum: same frame with CSUM^8'h01 -> ERR, load_err=1, cpu_hold stays 1, no restart.
  - A following valid frame clears load_err and completes normally.
- Length errors: N=0 -> ERR; N=129 -> ERR; in both cases no mem_we pulse is ever seen.
- Fetch path, idle with memory preloaded:
  - cpu_addr=0x4 -> cpu_instr = word 1.
  - cpu_addr=0x200 (word 128, out of range) -> cpu_instr = 0.
  - During a load, every fetch returns 0.
- Backpressure and data edge cases:
  - Random 0-5 cycle gaps between rx_valid pulses give identical memory contents to the gap-free run.
  - A data byte equal to A5 inside DATA is stored as data.
- Reset mid-load: assert reset after the 5th data byte -> next cycle state=IDLE, cpu_hold=0, mem_we=0, cpu_restart never pulses.
